parking_gate_ctrl: RTL and testbench
====================================

Name: parking_gate_ctrl

Overview:
Direction-detecting controller for the single-lane car park gate. It watches two optical beam sensors, A (outer) and B (inner), and classifies each complete beam-break sequence as a car entering or a car exiting. It owns the saturating occupancy count that sequences the lot's up/down counting and drives full/empty flags to the display and barrier logic. Aborted or malformed sequences never change the count.

Parameters:
CAPACITY, 15, maximum number of cars in the lot; must satisfy 1 ≤ CAPACITY ≤ 2^CNT_W−1.
CNT_W, 4, width of the occupancy count.
SYNC_STAGES, 2, number of flip-flop stages in the synchronizer on each sensor input (≥2).

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset (asserted when 0).
sensor_a  in  1  outer beam blocked = 1; asynchronous to clk.
sensor_b  in  1  inner beam blocked = 1; asynchronous to clk.
occupancy  out  CNT_W  current car count.
full  out  1  occupancy == CAPACITY.
empty  out  1  occupancy == 0.
enter_pulse  out  1  one-cycle strobe: a valid entry was counted.
exit_pulse  out  1  one-cycle strobe: a valid exit was counted.
ovf_err  out  1  one-cycle strobe: an entry completed while full; count held.
unf_err  out  1  one-cycle strobe: an exit completed while empty; count held.
seq_err  out  1  one-cycle strobe: an illegal sensor transition occurred.

Behaviour:
- Reset (async assert, sync-free deassert): FSM = IDLE, occupancy = 0, empty = 1, full = 0, all strobes = 0, synchronizer flops = 0.
- The FSM acts only on the synchronized pair ab = {a_s, b_s}. Raw-pin-to-FSM latency is SYNC_STAGES cycles.
- States: IDLE, EN_A, EN_AB, EN_B, EX_B, EX_AB, EX_A.
- IDLE:
  - 00 → stay.
  - 10 → EN_A.
  - 01 → EX_B.
  - 11 → stay, pulse seq_err.
- EN_A:
  - 10 → stay.
  - 11 → EN_AB.
  - 00 → IDLE (car backed out, silent).
  - 01 → IDLE, seq_err.
- EN_AB:
  - 11 → stay.
  - 01 → EN_B.
  - 10 → EN_A (reversing).
  - 00 → IDLE, seq_err.
- EN_B:
  - 01 → stay.
  - 11 → EN_AB.
  - 00 → IDLE with entry completion.
  - 10 → IDLE, seq_err.
- Exit states mirror the entry states with A and B swapped: EX_B on 01, EX_AB on 11, EX_A on 10. EX_A with 00 → IDLE with exit completion.
- Entry completion, registered on the same edge the FSM returns to IDLE:
  - if occupancy < CAPACITY: occupancy += 1 and enter_pulse = 1;
  - else occupancy held and ovf_err = 1.
- Exit completion:
  - if occupancy > 0: occupancy −= 1 and exit_pulse = 1;
  - else occupancy held and unf_err = 1.
- Total latency from the final raw sensor release to the strobe is SYNC_STAGES+1 clock edges. Strobes are high for exactly one cycle.
- full and empty are registered and update on the same edge as occupancy. They are never derived combinationally from the inputs.
- Only one car can be in the gate at a time, so at most one of enter_pulse / exit_pulse / ovf_err / unf_err is high in any cycle. seq_err is exclusive with all of them.
- occupancy never wraps: it saturates at 0 and at CAPACITY.
- Reset asserted mid-sequence: the in-flight car is discarded and occupancy returns to 0. After deassert the FSM restarts in IDLE; if sensors are still blocked at that point, the normal IDLE rules apply (e.g. 11 → seq_err).

Decomposition:
- Package parking_pkg:
  - state enum park_state_t (7 states, 3-bit encoding);
  - localparam sensor codes S_NONE = 2'b00, S_B = 2'b01, S_A = 2'b10, S_AB = 2'b11.
- Sub-module sensor_sync (parameter SYNC_STAGES; reset as above), instantiated once per sensor.
- FSM and occupancy register stay in parking_gate_ctrl.

Test Plan:
1. Reset, then entry sequence ab = 00 → 10 → 11 → 01 → 00, each held 4 cycles → enter_pulse once, 3 edges after the final release; occupancy = 1, empty = 0.
2. From occupancy 3, exit sequence 01 → 11 → 10 → 00 → exit_pulse once; occupancy = 2.
3. Fifteen entries, then a sixteenth → full = 1 after the 15th; the 16th gives ovf_err one cycle, occupancy stays 15, no enter_pulse. Then one exit → occupancy 14, full = 0.
4. Exit sequence at occupancy 0 → unf_err one cycle, occupancy 0, empty stays 1.
5. Abort and illegal paths, occupancy 5 throughout, no count change in any case:
   - 10 → 11 → 10 → 00 → silent return to IDLE, no strobes;
   - 00 → 11 from IDLE → seq_err;
   - 10 → 01 → seq_err.
6. Reset asserted asynchronously (mid-cycle) while in EN_AB with occupancy 7 → occupancy 0 immediately. With sensors at 01 after deassert → EX_B; completing 11 → 10 → 00 → unf_err.

Source files
------------

// File: rtl/parking_pkg.sv
// parking_pkg: shared state encoding and sensor codes for the parking gate controller
package parking_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EN_A  = 3'd1,
    EN_AB = 3'd2,
    EN_B  = 3'd3,
    EX_B  = 3'd4,
    EX_AB = 3'd5,
    EX_A  = 3'd6
  } park_state_t;
  localparam logic [1:0] S_NONE = 2'b00;
  localparam logic [1:0] S_B    = 2'b01;
  localparam logic [1:0] S_A    = 2'b10;
  localparam logic [1:0] S_AB   = 2'b11;
endpackage

// File: rtl/parking_gate_ctrl_sensor_sync.sv
// sensor_sync: multi-stage synchronizer bringing one asynchronous beam sensor into clk
module sensor_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], d};
  always_ff @(posedge clk or negedge reset)
    if (!reset) sync_q <= '0;
    else sync_q <= sync_d;
  assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: classifies A/B beam-break sequences as entries or exits
// and keeps a saturating occupancy count with full/empty flags and event strobes.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY    = 15,
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_a,
  input  logic             sensor_b,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             enter_pulse,
  output logic             exit_pulse,
  output logic             ovf_err,
  output logic             unf_err,
  output logic             seq_err
);
  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
  logic a_s, b_s;
  logic [1:0] ab;
  park_state_t state_q, state_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic full_q, full_d, empty_q, empty_d;
  logic enter_q, enter_d, exit_q, exit_d, ovf_q, ovf_d, unf_q, unf_d, seq_q, seq_d;
  logic ent, ext;
  sensor_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (.clk(clk), .reset(reset), .d(sensor_a), .q(a_s));
  sensor_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (.clk(clk), .reset(reset), .d(sensor_b), .q(b_s));
  assign ab = {a_s, b_s};
  // exit states mirror entry states with A and B swapped
  always_comb begin
    state_d = state_q;
    ent     = 1'b0;
    ext     = 1'b0;
    seq_d   = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = ab == S_A ? EN_A : ab == S_B ? EX_B : IDLE;
        seq_d   = ab == S_AB;
      end
      EN_A: begin
        state_d = ab == S_A ? EN_A : ab == S_AB ? EN_AB : IDLE;
        seq_d   = ab == S_B;
      end
      EN_AB: begin
        state_d = ab == S_AB ? EN_AB : ab == S_B ? EN_B : ab == S_A ? EN_A : IDLE;
        seq_d   = ab == S_NONE;
      end
      EN_B: begin
        state_d = ab == S_B ? EN_B : ab == S_AB ? EN_AB : IDLE;
        ent     = ab == S_NONE;
        seq_d   = ab == S_A;
      end
      EX_B: begin
        state_d = ab == S_B ? EX_B : ab == S_AB ? EX_AB : IDLE;
        seq_d   = ab == S_A;
      end
      EX_AB: begin
        state_d = ab == S_AB ? EX_AB : ab == S_A ? EX_A : ab == S_B ? EX_B : IDLE;
        seq_d   = ab == S_NONE;
      end
      EX_A: begin
        state_d = ab == S_A ? EX_A : ab == S_AB ? EX_AB : IDLE;
        ext     = ab == S_NONE;
        seq_d   = ab == S_B;
      end
      default: state_d = IDLE;
    endcase
    enter_d = ent && occ_q < CAP;
    ovf_d   = ent && !(occ_q < CAP);
    exit_d  = ext && occ_q != '0;
    unf_d   = ext && occ_q == '0;
    occ_d   = enter_d ? occ_q + 1'b1 : exit_d ? occ_q - 1'b1 : occ_q;
    full_d  = occ_d == CAP;
    empty_d = occ_d == '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      occ_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      seq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      enter_q <= enter_d;
      exit_q  <= exit_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      seq_q   <= seq_d;
    end
  assign occupancy   = occ_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign enter_pulse = enter_q;
  assign exit_pulse  = exit_q;
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;
  assign seq_err     = seq_q;
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: scenario-level reference model driving directed and random gate traffic
module tb_parking_gate_ctrl;
  localparam int CAP = 15;
  localparam int LAT = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sensor_a = 1'b0, sensor_b = 1'b0;
  logic [3:0] occupancy;
  logic full, empty, enter_pulse, exit_pulse, ovf_err, unf_err, seq_err;
  int errors = 0, checks = 0;
  int cyc = 0;
  int model_occ = 0;
  int n_ent, n_ext, n_ovf, n_unf, n_seq, stb_cyc;
  bit excl_bad;

  parking_gate_ctrl #(.CAPACITY(CAP), .CNT_W(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sensor_a(sensor_a), .sensor_b(sensor_b),
    .occupancy(occupancy), .full(full), .empty(empty),
    .enter_pulse(enter_pulse), .exit_pulse(exit_pulse),
    .ovf_err(ovf_err), .unf_err(unf_err), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      n_ent += int'(enter_pulse);
      n_ext += int'(exit_pulse);
      n_ovf += int'(ovf_err);
      n_unf += int'(unf_err);
      n_seq += int'(seq_err);
      if (enter_pulse || exit_pulse || ovf_err || unf_err) stb_cyc = cyc;
      if (int'(enter_pulse) + int'(exit_pulse) + int'(ovf_err) + int'(unf_err) + int'(seq_err) > 1)
        excl_bad = 1'b1;
    end
  endtask

  // kinds: 0/1 entry (1 with reversal), 2 exit, 3/4/5 aborts, 6/7/8 illegal
  task automatic run_seq(input int kind, input int hold);
    logic [11:0] pat;
    int len, h, rel;
    int e_ent, e_ext, e_ovf, e_unf, e_seq;
    bit done;
    n_ent = 0; n_ext = 0; n_ovf = 0; n_unf = 0; n_seq = 0; stb_cyc = -1; excl_bad = 1'b0;
    e_ent = 0; e_ext = 0; e_ovf = 0; e_unf = 0; e_seq = 0;
    done = kind <= 2;
    case (kind)
      0: begin pat = {6'b0, 2'b01, 2'b11, 2'b10}; len = 3; end
      1: begin pat = {2'b0, 2'b01, 2'b11, 2'b10, 2'b11, 2'b10}; len = 5; end
      2: begin pat = {6'b0, 2'b10, 2'b11, 2'b01}; len = 3; end
      3: begin pat = {10'b0, 2'b10}; len = 1; end
      4: begin pat = {6'b0, 2'b10, 2'b11, 2'b10}; len = 3; end
      5: begin pat = {6'b0, 2'b01, 2'b11, 2'b01}; len = 3; end
      6: begin pat = {10'b0, 2'b11}; len = 1; end
      7: begin pat = {8'b0, 2'b01, 2'b10}; len = 2; end
      default: begin pat = {8'b0, 2'b11, 2'b10}; len = 2; end
    endcase
    if (kind <= 1) begin
      if (model_occ < CAP) begin e_ent = 1; model_occ++; end else e_ovf = 1;
    end else if (kind == 2) begin
      if (model_occ > 0) begin e_ext = 1; model_occ--; end else e_unf = 1;
    end else if (kind >= 6) e_seq = 1;
    for (int i = 0; i < len; i++) begin
      {sensor_a, sensor_b} = pat[2*i +: 2];
      h = kind == 6 ? 1 : hold > 0 ? hold : int'($urandom_range(1, 4));
      cycles(h);
    end
    {sensor_a, sensor_b} = 2'b00;
    rel = cyc;
    cycles(6);
    checks++;
    if ({n_ent, n_ext, n_ovf, n_unf, n_seq} !== {e_ent, e_ext, e_ovf, e_unf, e_seq}) begin
      errors++;
      $display("FAIL strobes kind=%0d got ent=%0d ext=%0d ovf=%0d unf=%0d seq=%0d want ent=%0d ext=%0d ovf=%0d unf=%0d seq=%0d",
               kind, n_ent, n_ext, n_ovf, n_unf, n_seq, e_ent, e_ext, e_ovf, e_unf, e_seq);
    end
    checks++;
    if (occupancy !== 4'(model_occ) || full !== (model_occ == CAP) || empty !== (model_occ == 0)) begin
      errors++;
      $display("FAIL count kind=%0d got occ=%0d full=%b empty=%b want occ=%0d full=%b empty=%b",
               kind, occupancy, full, empty, model_occ, model_occ == CAP, model_occ == 0);
    end
    checks++;
    if (excl_bad) begin
      errors++;
      $display("FAIL exclusive kind=%0d got overlapping strobes want at most one", kind);
    end
    if (done) begin
      checks++;
      if (stb_cyc - rel !== LAT) begin
        errors++;
        $display("FAIL latency kind=%0d got %0d edges want %0d", kind, stb_cyc - rel, LAT);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    {sensor_a, sensor_b} = 2'b00;
    model_occ = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic set_occ(input int n);
    do_reset();
    for (int i = 0; i < n; i++) run_seq(0, 0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({occupancy, full, empty, enter_pulse, exit_pulse, ovf_err, unf_err, seq_err} !== {4'd0, 7'b0100000}) begin
      errors++;
      $display("FAIL reset got occ=%0d full=%b empty=%b strobes=%b%b%b%b%b want occ=0 full=0 empty=1 strobes=00000",
               occupancy, full, empty, enter_pulse, exit_pulse, ovf_err, unf_err, seq_err);
    end
    do_reset();
  endtask

  task automatic test_entry();
    do_reset();
    run_seq(0, 4);
  endtask

  task automatic test_exit();
    set_occ(3);
    run_seq(2, 4);
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < CAP + 1; i++) run_seq(0, 4);
    run_seq(2, 4);
  endtask

  task automatic test_underflow();
    do_reset();
    run_seq(2, 4);
  endtask

  task automatic test_abort();
    set_occ(5);
    run_seq(4, 4);
    run_seq(6, 1);
    run_seq(7, 4);
  endtask

  task automatic test_async_reset();
    set_occ(7);
    {sensor_a, sensor_b} = 2'b10;
    repeat (4) @(negedge clk);
    {sensor_a, sensor_b} = 2'b11;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    model_occ = 0;
    #1;
    checks++;
    if (occupancy !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got occ=%0d empty=%b full=%b want occ=0 empty=1 full=0", occupancy, empty, full);
    end
    {sensor_a, sensor_b} = 2'b01;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_seq(2, 4);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 80; i++) run_seq(int'($urandom_range(0, 8)), 0);
  endtask

  initial begin
    test_reset();
    test_entry();
    test_exit();
    test_fill();
    test_underflow();
    test_abort();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
